// File: rtl/sccb_write_master.sv
// rtl/sccb_write_master.sv - SCCB/I2C 4-byte register write master; SCCB_ACK_CHECK_EN enables NACK abort
// Open-drain SCL/SDA are registered; quarter-bit phases are CLK_DIV clk_in cycles long.
module sccb_write_master #(
  parameter int         CLK_DIV  = 250,
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [23:0] cmd_data_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        nack_out,
  inout  logic        scl_pin,
  inout  logic        sda_pin
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_BUF
  } state_t;

  state_t        state, state_n;
  logic [1:0]    quarter, quarter_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [1:0]    byte_cnt, byte_n;
  logic [31:0]   shreg, shreg_n;
  logic          nack_q, nack_n;
  logic          done_n, tick, ack_high;
  logic          scl_low, sda_low, scl_low_n, sda_low_n;

  assign scl_pin       = scl_low ? 1'b0 : 1'bz;
  assign sda_pin       = sda_low ? 1'b0 : 1'bz;
  assign cmd_ready_out = (state == S_IDLE);
  assign busy_out      = (state != S_IDLE);

`ifdef SCCB_ACK_CHECK_EN
  logic [1:0] sda_sync;
  logic       nack_pulse;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sda_sync   <= 2'b11;
      nack_pulse <= 1'b0;
    end else begin
      sda_sync   <= {sda_sync[0], sda_pin};
      nack_pulse <= done_n & nack_q;
    end
  end

  assign ack_high = sda_sync[1];
  assign nack_out = nack_pulse;
`else
  assign ack_high = 1'b0;
  assign nack_out = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    quarter_n = quarter;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    byte_n    = byte_cnt;
    shreg_n   = shreg;
    nack_n    = nack_q;
    done_n    = 1'b0;
    tick      = (cnt == CW'(CLK_DIV - 1));

    if (state == S_IDLE) begin
      if (cmd_valid_in) begin
        state_n   = S_START;
        quarter_n = 2'd0;
        cnt_n     = '0;
        bit_n     = 3'd7;
        byte_n    = 2'd0;
        shreg_n   = {DEV_ADDR, 1'b0, cmd_data_in};
        nack_n    = 1'b0;
      end
    end else begin
      cnt_n = tick ? '0 : cnt + CW'(1);
      if (tick) begin
        quarter_n = quarter + 2'd1;
        case (state)
          S_START: if (quarter == 2'd1) begin
            state_n   = S_BIT;
            quarter_n = 2'd0;
          end
          S_BIT: if (quarter == 2'd3) begin
            // Shift after every bit so the next byte's MSB is ready when ACK ends
            quarter_n = 2'd0;
            shreg_n   = {shreg[30:0], 1'b0};
            if (bit_cnt == 3'd0) state_n = S_ACK;
            else bit_n = bit_cnt - 3'd1;
          end
          S_ACK: begin
            if (quarter == 2'd2) nack_n = ack_high;
            if (quarter == 2'd3) begin
              quarter_n = 2'd0;
              bit_n     = 3'd7;
              if (byte_cnt == 2'd3 || nack_q) begin
                state_n = S_STOP;
              end else begin
                byte_n  = byte_cnt + 2'd1;
                state_n = S_BIT;
              end
            end
          end
          S_STOP: if (quarter == 2'd2) begin
            state_n   = S_BUF;
            quarter_n = 2'd0;
          end
          S_BUF: begin
            state_n   = S_IDLE;
            quarter_n = 2'd0;
            done_n    = 1'b1;
          end
          default: state_n = S_IDLE;
        endcase
      end
    end

    // Pin levels are decoded from the next phase so the pins themselves are flops
    scl_low_n = 1'b0;
    sda_low_n = 1'b0;
    case (state_n)
      S_START: sda_low_n = (quarter_n == 2'd1);
      S_BIT: begin
        scl_low_n = ~quarter_n[1];
        sda_low_n = ~shreg_n[31];
      end
      S_ACK:  scl_low_n = ~quarter_n[1];
      S_STOP: begin
        scl_low_n = (quarter_n == 2'd0);
        sda_low_n = (quarter_n != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      quarter  <= 2'd0;
      cnt      <= '0;
      bit_cnt  <= 3'd7;
      byte_cnt <= 2'd0;
      shreg    <= '0;
      nack_q   <= 1'b0;
      done_out <= 1'b0;
      scl_low  <= 1'b0;
      sda_low  <= 1'b0;
    end else begin
      state    <= state_n;
      quarter  <= quarter_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      shreg    <= shreg_n;
      nack_q   <= nack_n;
      done_out <= done_n;
      scl_low  <= scl_low_n;
      sda_low  <= sda_low_n;
    end
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// tb/tb_sccb_write_master.sv - self-checking bench for sccb_write_master
// Bus monitor decodes bytes from the pins; a slave model ACKs all bytes except nack_at.
`timescale 1ns/1ps
module tb_sccb_write_master;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_data = '0;
  logic        cmd_ready, busy, done, nack;
  wire         scl, sda;
  logic        slave_ack = 1'b0;

  pullup (scl);
  pullup (sda);
  assign sda = slave_ack ? 1'b0 : 1'bz;

  sccb_write_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h3C)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_data_in(cmd_data), .busy_out(busy), .done_out(done), .nack_out(nack),
    .scl_pin(scl), .sda_pin(sda)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave, sampled on the falling clock edge
  logic       pscl = 1'b1, psda = 1'b1, in_txn = 1'b0;
  logic [8:0] sh = '0;
  logic [7:0] got[$];
  int bitpos = 0, nbytes = 0, starts = 0, stops = 0, proto_err = 0;
  int nack_at = 4, last_stop = 0, last_gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn = 1'b0; bitpos = 0; slave_ack = 1'b0;
    end else if (pscl && scl && (psda != sda)) begin
      if (!sda) begin
        if (in_txn) proto_err++;
        if (stops > 0) last_gap = cyc - last_stop;
        in_txn = 1'b1; starts++; bitpos = 0; nbytes = 0;
      end else begin
        // the STOP's own SCL rise registers as one stray bit
        if (!in_txn || bitpos != 1) proto_err++;
        in_txn = 1'b0; stops++; last_stop = cyc; bitpos = 0;
      end
    end else if (!pscl && scl && in_txn) begin
      sh = {sh[7:0], sda};
      bitpos++;
      if (bitpos == 9) begin
        got.push_back(sh[8:1]); nbytes++; bitpos = 0;
      end
    end else if (pscl && !scl && in_txn) begin
      if (bitpos == 8) slave_ack = (nbytes != nack_at);
      else if (bitpos == 0) slave_ack = 1'b0;
    end
    pscl = scl;
    psda = sda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes actually sent on the bus, given which byte the slave refuses
  function automatic int exp_nbytes(input int nack_byte);
`ifdef SCCB_ACK_CHECK_EN
    return (nack_byte < 4) ? nack_byte + 1 : 4;
`else
    return 4;
`endif
  endfunction

  task automatic issue(input logic [23:0] d, output int t0);
    @(negedge clk);
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_data = d;
    @(negedge clk);
    t0 = cyc; cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_done(input int t0, output int lat, output logic nk);
    lat = -1; nk = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0; nk = nack;
        chk("ready_with_done", 32'(cmd_ready), 32'd1);
        break;
      end
    end
  endtask

  task automatic run_txn(input logic [23:0] d, input int nack_byte, input bit holdoff);
    int t0, lat, nb, s0, p0, e0;
    logic nk;
    logic [7:0] eb[4];
    got.delete();
    s0 = starts; p0 = stops; e0 = proto_err; nack_at = nack_byte;
    eb[0] = 8'h78; eb[1] = d[23:16]; eb[2] = d[15:8]; eb[3] = d[7:0];
    nb = exp_nbytes(nack_byte);
    issue(d, t0);
    if (holdoff) begin
      foreach (eb[k]) begin
        if (k < 3) begin
          while (cyc - t0 < (k == 0 ? 10 : (k == 1 ? 100 : 300))) @(negedge clk);
          cmd_valid = 1'b1; cmd_data = ~d;
          chk("ready_held_off", 32'(cmd_ready), 32'd0);
          @(negedge clk);
          cmd_valid = 1'b0;
        end
      end
    end
    wait_done(t0, lat, nk);
    chk("latency", 32'(lat), 32'((6 + 36 * nb) * CLK_DIV));
    chk("nack_out", 32'(nk), 32'(nb < 4));
    chk("byte_count", 32'(got.size()), 32'(nb));
    for (int i = 0; i < nb && i < got.size(); i++) chk($sformatf("byte%0d", i), 32'(got[i]), 32'(eb[i]));
    chk("start_count", 32'(starts - s0), 32'd1);
    chk("stop_count", 32'(stops - p0), 32'd1);
    chk("protocol", 32'(proto_err - e0), 32'd0);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int t0, t1, lat, s0, seen_done;
    logic nk;
    logic [7:0] eb2[8];

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_nack", 32'(nack), 32'd0);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(24'hAABBCC, 4, 1'b1);

    // Back-to-back with valid held high
    got.delete(); nack_at = 4; s0 = starts;
    eb2 = '{8'h78, 8'h30, 8'h08, 8'h12, 8'h78, 8'h31, 8'h03, 8'h00};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 24'h300812;
    @(negedge clk);
    t0 = cyc; cmd_data = 24'h310300;
    wait_done(t0, lat, nk);
    chk("b2b_latency1", 32'(lat), 32'(150 * CLK_DIV));
    @(negedge clk);
    t1 = cyc; cmd_valid = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_accept_ready", 32'(cmd_ready), 32'd0);
    wait_done(t1, lat, nk);
    chk("b2b_latency2", 32'(lat), 32'(150 * CLK_DIV));
    chk("b2b_bytes", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("b2b_byte%0d", i), 32'(got[i]), 32'(eb2[i]));
    chk("b2b_starts", 32'(starts - s0), 32'd2);
    chk("b2b_gap_ok", 32'(last_gap >= 4), 32'd1);

    run_txn(24'hAABBCC, 1, 1'b0);
    for (int i = 0; i < 4; i++) run_txn(24'($urandom), int'($urandom_range(0, 4)), 1'b0);

    // Reset in the middle of byte 1 bit 3 (quarter 50), data 0x00 so both pins are low
    nack_at = 4;
    issue(24'h00AA33, t0);
    while (cyc - t0 < 200) @(negedge clk);
    chk("pre_rst_scl", 32'(scl), 32'd0);
    chk("pre_rst_sda", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", 32'(scl), 32'd1);
    chk("mid_rst_sda", 32'(sda), 32'd1);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    seen_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("no_done_after_abort", 32'(seen_done), 32'd0);
    run_txn(24'h123456, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_write_master.md
Name: sccb_write_master

Overview:
Bit-level I2C/SCCB write engine sitting directly below the camera register sequencer. It accepts one 24-bit register write command (16-bit register address plus 8-bit data) through a valid/ready handshake. It serialises the command as a single 4-byte bus write to the OV5640, driving open-drain SCL and SDA, then reports completion. Writes only; there are no reads and no clock stretching.

Parameters:
CLK_DIV, 250, clk_in cycles per quarter bit-period (100 MHz / (4*250) = 100 kHz SCL); legal range >= 2
DEV_ADDR, 7'h3C, 7-bit device address; first byte on the bus is {DEV_ADDR,1'b0}

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous, active-low reset
cmd_valid_in  input  1  command valid
cmd_ready_out  output  1  block can accept a command
cmd_data_in  input  24  [23:8] register address, [7:0] register data
busy_out  output  1  transaction in progress
done_out  output  1  one-cycle pulse when a transaction finishes, successful or aborted
nack_out  output  1  one-cycle pulse, coincident with done_out, if a NACK aborted the transaction (ACK_CHECK only)
scl_pin  inout  1  open drain: driven 0 or high-Z, never driven 1
sda_pin  inout  1  open drain: driven 0 or high-Z, never driven 1

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE; scl_pin and sda_pin released (Z) immediately.
  - cmd_ready_out=1, busy_out=0, done_out=0, nack_out=0.
- Reset asserted mid-transaction:
  - Aborts with no STOP generated; bus released at once.
  - No done_out pulse.
- Handshake:
  - Transfer occurs on a rising edge with cmd_valid_in && cmd_ready_out.
  - cmd_data_in is latched into a 32-bit shift register as {DEV_ADDR,0,data[23:0]}.
  - Next cycle: cmd_ready_out=0 and busy_out=1.
  - cmd_ready_out is 1 only in IDLE; a valid with ready low is ignored.
- Timing base: quarter counter counts 0..CLK_DIV-1. A phase advances when the counter reaches CLK_DIV-1. The counter restarts at 0 on acceptance.
- States and quarters (in order):
  - START, 2 quarters: Q0 SCL=Z, SDA=Z. Q1 SCL=Z, SDA=0.
  - BIT, 4 quarters per bit, MSB first: Q0 SCL=0, SDA=bit (0 drives low, 1 releases). Q1 SCL=0. Q2 SCL=Z. Q3 SCL=Z.
  - ACK, 4 quarters after every 8 bits: same pattern with SDA released. SDA is sampled on the last cycle of Q2.
  - The BIT/ACK pair repeats for 4 bytes.
  - STOP, 3 quarters: Q0 SCL=0, SDA=0. Q1 SCL=Z, SDA=0. Q2 SCL=Z, SDA=Z.
  - BUF, 1 quarter: bus idle (bus-free time).
  - Then IDLE.
- Bus lines:
  - SDA changes only while SCL is driven low, except at START and STOP.
  - SCL and SDA are registered outputs; no combinational path from any input.
- Latency:
  - Acceptance edge to done_out: 2 + 4*9*4 + 3 + 1 = 150 quarters = 150*CLK_DIV cycles.
  - done_out is asserted on the same edge at which cmd_ready_out returns to 1.
  - Back-to-back: a command presented while done_out=1 is accepted on the next edge.
- Counters:
  - 3-bit bit counter (7 down to 0) and 2-bit byte counter (0..3).
  - After the ACK of byte 3, go to STOP.
- Input sampling: the ACK sample reads sda_pin through a 2-flop synchroniser; the sample point is Q2 end.

Optional Feature:
Macro SCCB_ACK_CHECK_EN.
- Defined:
  - SDA sampled high at any ACK slot is a NACK.
  - After a NACK, the remaining bytes are skipped and the next state is STOP, then BUF.
  - done_out and nack_out pulse together.
  - Aborted latency is shorter: for a NACK on byte k (0..3), latency = (2 + 36*(k+1) + 4)*CLK_DIV.
- Undefined:
  - ACK slots are still clocked with SDA released, but the sample is ignored (SCCB "don't care" bit).
  - nack_out is tied to 0.

Test Plan:
- Basic write, CLK_DIV=4, DEV_ADDR=7'h3C, pull-ups on both pins, slave model ACKs: cmd_data_in=24'hAABBCC -> decoded bytes 0x78,0xAA,0xBB,0xCC; one START and one STOP; done_out exactly 600 cycles after acceptance; nack_out=0.
- Back-to-back: 24'h300812 then 24'h310300 presented with valid held high -> second accepted on the cycle done_out pulses; bytes 0x78,0x30,0x08,0x12 then 0x78,0x31,0x03,0x00; bus idle >= 4 cycles between STOP and the next START.
- Handshake hold-off: cmd_valid_in pulsed at cycles 10, 100 and 300 of a busy transaction -> ignored; cmd_ready_out stays 0 until done_out.
- Bus protocol checker over all runs: SDA never transitions while SCL is high except START/STOP; neither pin is ever driven to 1.
- NACK, with SCCB_ACK_CHECK_EN, slave NACKs byte 1 (0xAA) -> STOP follows, no 0xBB/0xCC bits; done_out and nack_out pulse at (2+72+4)*4 = 312 cycles. Without the macro: full 600-cycle transaction, nack_out=0.
- Reset mid-transaction: rst_n_in low at cycle 200 of a transfer -> both pins Z within the same cycle; cmd_ready_out=1; no done_out; a new 24'h123456 after release completes normally.
